// File: rtl/im_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional feature macro used by the top: FETCH_PERF_EN.
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_WORDS = 2048;

  // One past the last legal byte address, kept 33 bits wide so the window
  // check cannot alias through 32-bit wrap.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } qstate_e;

  // True when the byte address lies inside [IM_BASE, IM_BASE+4*IM_WORDS).
  function automatic logic in_window(input logic [31:0] pc);
    return ({1'b0, pc} >= {1'b0, IM_BASE}) && ({1'b0, pc} < IM_END);
  endfunction

endpackage

// File: rtl/im_fetch_ctrl_if.sv
// IM read bus plus decode-side valid/ready handshake of the fetch sequencer.
interface im_fetch_ctrl_if;
  logic [10:0] im_addr;
  logic [31:0] im_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  // master: the fetch sequencer
  modport master (
    output im_addr, out_valid, out_pc, out_instr,
    input  im_rdata, out_ready
  );

  // slave: the IM / decode side
  modport slave (
    input  im_addr, out_valid, out_pc, out_instr,
    output im_rdata, out_ready
  );
endinterface

// File: rtl/im_fetch_ctrl_fifo.sv
// DEPTH-entry circular fetch queue. Flush wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output qstate_e                  state_o,
  output fetch_entry_t             head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  // Occupancy follows push/pop; a flush empties the queue outright.
  always_comb begin
    count_d = count_q;
    if (flush_i)
      count_d = '0;
    else if (push_i && !pop_i)
      count_d = count_q + 1'b1;
    else if (!push_i && pop_i)
      count_d = count_q - 1'b1;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage is reset so the head reads as zero out of reset. When full with
  // a simultaneous pop, wr_ptr==rd_ptr and the popped slot is reused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Queue state is a pure function of occupancy.
  always_comb begin
    state_o = Q_PARTIAL;
    if (count_q == '0)
      state_o = Q_EMPTY;
    else if (count_q == CW'(DEPTH))
      state_o = Q_FULL;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the IM word address,
// queues {pc, instr} for decode, handles redirect flushes and fetch faults.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module im_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  im_fetch_ctrl_if.master      bus,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic                 fault,
  output logic [31:0]          fault_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_pc_q, fault_pc_d;
  logic [CW-1:0] count;
  qstate_e       qstate;
  fetch_entry_t  head, push_data;
  logic          pop, can_push, bad, push;

  assign pop       = bus.out_valid & bus.out_ready;
  assign bad       = (pc_q[1:0] != 2'b00) || !in_window(pc_q);
  assign can_push  = !stall && !fault_q && !redirect && ((qstate != Q_FULL) || pop);
  assign push      = can_push && !bad;
  assign push_data = '{pc: pc_q, instr: bus.im_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .flush_i    (redirect),
    .count_o    (count),
    .state_o    (qstate),
    .head_o     (head)
  );

  // PC/fault next state: redirect beats everything; a bad PC under can_push
  // latches the fault and freezes the PC instead of pushing.
  always_comb begin
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      fault_d = 1'b0;
    end else if (can_push) begin
      if (bad) begin
        fault_d    = 1'b1;
        fault_pc_d = pc_q;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // PC and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // IM is addressed by pc[12:2] directly; the IM aliases IM_BASE onto that.
  assign bus.im_addr   = pc_q[12:2];
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign fault         = fault_q;
  assign fault_pc      = fault_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Free-running counters; redirect does not touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall || (qstate == Q_FULL && !pop)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl. The IM model aliases by pc[12:2], so
// word k (byte IM_BASE+4k) sits at im_addr (0x400+k) mod 2048 and holds k.
module tb_im_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] imem [0:2047];

  im_fetch_ctrl_if fif ();

  im_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (fif.master),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fault      (fault),
    .fault_pc   (fault_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  assign fif.im_rdata = imem[fif.im_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, 32'(fif.out_valid), 32'd1);
    chk({tag, "_pc"}, fif.out_pc, pc);
    chk({tag, "_instr"}, fif.out_instr, ins);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    nxt();
    redirect    = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) imem[a] = 32'((a - 32'h400) & 32'h7FF);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    fif.out_ready = 1'b1;
    nxt(); nxt();

    // reset state
    chk("rst_valid", 32'(fif.out_valid), 32'd0);
    chk("rst_pc", fif.out_pc, 32'h0);
    chk("rst_instr", fif.out_instr, 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_im_addr", 32'(fif.im_addr), 32'h400);

    // streaming from reset
    rst_n = 1'b1;
    #1 chk("rel_valid0", 32'(fif.out_valid), 32'd0);
    nxt();
    head("s0", 32'h3000, 32'd0);
    nxt();
    head("s1", 32'h3004, 32'd1);
    nxt();
    head("s2", 32'h3008, 32'd2);

    // backpressure: head 0x3008 held, 0x300C queued, pc frozen at 0x3010
    fif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nxt();
      head("hold", 32'h3008, 32'd2);
    end
    chk("hold_im_addr", 32'(fif.im_addr), 32'h404);

    // drain in order, no gap
    fif.out_ready = 1'b1;
    nxt(); head("d0", 32'h300C, 32'd3);
    nxt(); head("d1", 32'h3010, 32'd4);
    nxt(); head("d2", 32'h3014, 32'd5);

    // redirect while full
    fif.out_ready = 1'b0;
    nxt();
    chk("pre_redir_full_pc", fif.out_pc, 32'h3014);
    fif.out_ready = 1'b1;
    do_redirect(32'h3100);
    chk("redir_valid0", 32'(fif.out_valid), 32'd0);
    chk("redir_im_addr", 32'(fif.im_addr), 32'h440);
    nxt();
    head("redir", 32'h3100, 32'h40);

    // misaligned redirect faults
    do_redirect(32'h3102);
    chk("mis_valid0", 32'(fif.out_valid), 32'd0);
    nxt();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h3102);
    chk("mis_valid1", 32'(fif.out_valid), 32'd0);
    nxt();
    chk("mis_frozen", 32'(fif.im_addr), 32'h440);
    chk("mis_valid2", 32'(fif.out_valid), 32'd0);

    // recovery
    do_redirect(32'h3000);
    chk("rec_fault", 32'(fault), 32'd0);
    chk("rec_valid0", 32'(fif.out_valid), 32'd0);
    nxt();
    head("rec", 32'h3000, 32'd0);

    // top-of-window: last word delivered, next PC faults
    do_redirect(32'h4FFC);
    nxt();
    head("top", 32'h4FFC, 32'h7FF);
    chk("top_nofault", 32'(fault), 32'd0);
    nxt();
    chk("top_valid", 32'(fif.out_valid), 32'd0);
    chk("top_fault", 32'(fault), 32'd1);
    chk("top_fault_pc", fault_pc, 32'h5000);

    // stall freezes pc, redirect still loads it
    stall = 1'b1;
    do_redirect(32'h3020);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(fif.out_valid), 32'd0);
      chk("stall_im_addr", 32'(fif.im_addr), 32'h408);
      nxt();
    end
    stall = 1'b0;
    nxt();
    head("unstall", 32'h3020, 32'd8);

    // async reset with the queue full
    fif.out_ready = 1'b0;
    nxt(); nxt();
    head("prerst", 32'h3020, 32'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(fif.out_valid), 32'd0);
    chk("arst_im_addr", 32'(fif.im_addr), 32'h400);
    chk("arst_pc", fif.out_pc, 32'h0);
    chk("arst_fault", 32'(fault), 32'd0);
    nxt();
    fif.out_ready = 1'b1;
    rst_n = 1'b1;
    nxt(); head("r0", 32'h3000, 32'd0);
    nxt(); head("r1", 32'h3004, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
